// File: rtl/cpu_ad48_wb_arb.sv
// cpu_ad48_wb_arb: two-slot round-robin write-back arbiter with per-register busy scoreboard
// Optional CPU_AD48_WB_ARB_STATS_EN adds a saturating conflict_cnt output
module cpu_ad48_wb_arb #(
  parameter int DW = 48,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic          r0_bank,
  input  logic [AW-1:0] r0_idx,
  input  logic [DW-1:0] r0_data,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_bank,
  input  logic [AW-1:0] r1_idx,
  input  logic [DW-1:0] r1_data,
  output logic          we_a,
  output logic          we_d,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic [7:0]    busy_a,
  output logic [7:0]    busy_d
`ifdef CPU_AD48_WB_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);
  logic [1:0]    s_full, s_bank, gnt, rdy, acc;
  logic [AW-1:0] s_idx [2];
  logic [DW-1:0] s_data [2];
  logic          last, gid, gany;
  always_comb begin
    gany = |s_full;
    gid = &s_full ? ~last : s_full[1];
    gnt = gany ? (gid ? 2'b10 : 2'b01) : 2'b00;
    rdy = flush ? 2'b00 : (~s_full | gnt);
    acc = rdy & {r1_valid, r0_valid};
    we_d = gany && s_bank[gid];
    we_a = gany && !s_bank[gid] && s_idx[gid] != '0;
    waddr = gany ? s_idx[gid] : '0;
    wdata = gany ? s_data[gid] : '0;
    busy_a = '0;
    busy_d = '0;
    for (int n = 0; n < 2; n++) begin
      busy_a = busy_a | ((s_full[n] && !s_bank[n]) ? 8'(1) << s_idx[n] : 8'h00);
      busy_d = busy_d | ((s_full[n] && s_bank[n]) ? 8'(1) << s_idx[n] : 8'h00);
    end
  end
  assign r0_ready = rdy[0];
  assign r1_ready = rdy[1];
  // a granted slot empties unless reloaded by a same-cycle accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_full <= '0;
      s_bank <= '0;
      s_idx  <= '{default: '0};
      s_data <= '{default: '0};
      last   <= 1'b1;
    end else begin
      s_full <= acc | (s_full & ~gnt & {2{~flush}});
      if (gany) last <= gid;
      if (acc[0]) begin
        s_bank[0] <= r0_bank;
        s_idx[0]  <= r0_idx;
        s_data[0] <= r0_data;
      end
      if (acc[1]) begin
        s_bank[1] <= r1_bank;
        s_idx[1]  <= r1_idx;
        s_data[1] <= r1_data;
      end
    end
  end
`ifdef CPU_AD48_WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) conflict_cnt <= '0;
    else if (&s_full && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cpu_ad48_wb_arb.sv
// tb_cpu_ad48_wb_arb: vector table plus write scoreboard for the write-back arbiter
module tb_cpu_ad48_wb_arb;
  logic        clk = 0, resetn, flush;
  logic        r0_valid, r0_ready, r0_bank, r1_valid, r1_ready, r1_bank;
  logic [2:0]  r0_idx, r1_idx, waddr;
  logic [47:0] r0_data, r1_data, wdata;
  logic        we_a, we_d;
  logic [7:0]  busy_a, busy_d;
`ifdef CPU_AD48_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif
  always #5 clk = ~clk;
  cpu_ad48_wb_arb #(.DW(48), .AW(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_bank(r0_bank), .r0_idx(r0_idx), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_bank(r1_bank), .r1_idx(r1_idx), .r1_data(r1_data),
    .we_a(we_a), .we_d(we_d), .waddr(waddr), .wdata(wdata), .busy_a(busy_a), .busy_d(busy_d)
`ifdef CPU_AD48_WB_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  typedef struct {
    logic v0, b0; logic [2:0] i0; logic [15:0] d0;
    logic v1, b1; logic [2:0] i1; logic [15:0] d1;
    logic fl, er0, er1, ewa, ewd; logic [2:0] ea; logic [15:0] ed;
    logic [7:0] eba, ebd; logic p0, p1;
  } vec_t;
  typedef struct { logic b; logic [2:0] i; logic [47:0] d; } wr_t;
  vec_t tbl [16];
  wr_t  exp_q [$];
  wr_t  mw;
  int   checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (resetn && (we_a || we_d)) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_write: got we_d=%0d idx=%0d data=%0h required no write", we_d, waddr, wdata);
    end else begin
      mw = exp_q.pop_front();
      chk("wr_bank", 64'(we_d), 64'(mw.b));
      chk("wr_idx", 64'(waddr), 64'(mw.i));
      chk("wr_data", 64'(wdata), 64'(mw.d));
      chk("wr_one_we", 64'(we_a & we_d), 64'd0);
    end
  end
  task automatic apply(input vec_t t, input string nm);
    r0_valid = t.v0; r0_bank = t.b0; r0_idx = t.i0; r0_data = 48'(t.d0);
    r1_valid = t.v1; r1_bank = t.b1; r1_idx = t.i1; r1_data = 48'(t.d1);
    flush = t.fl;
    if (t.p0) exp_q.push_back('{b: t.b0, i: t.i0, d: 48'(t.d0)});
    if (t.p1) exp_q.push_back('{b: t.b1, i: t.i1, d: 48'(t.d1)});
    @(negedge clk);
    chk({nm, ".r0_ready"}, 64'(r0_ready), 64'(t.er0));
    chk({nm, ".r1_ready"}, 64'(r1_ready), 64'(t.er1));
    chk({nm, ".we_a"}, 64'(we_a), 64'(t.ewa));
    chk({nm, ".we_d"}, 64'(we_d), 64'(t.ewd));
    chk({nm, ".waddr"}, 64'(waddr), 64'(t.ea));
    chk({nm, ".wdata"}, 64'(wdata), 64'(t.ed));
    chk({nm, ".busy_a"}, 64'(busy_a), 64'(t.eba));
    chk({nm, ".busy_d"}, 64'(busy_d), 64'(t.ebd));
    @(posedge clk); #1;
  endtask
  task automatic idle();
    r0_valid = 0; r1_valid = 0; flush = 0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask
  initial begin
    resetn = 0; flush = 0;
    r0_valid = 0; r0_bank = 0; r0_idx = 0; r0_data = 0;
    r1_valid = 0; r1_bank = 0; r1_idx = 0; r1_data = 0;
    //            v0 b0 i0 d0   v1 b1 i1 d1  fl r0 r1 wa wd ea ed   busy_a busy_d p0 p1
    tbl[0]  = '{1, 1, 1, 7,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 1, 0};
    tbl[1]  = '{0, 0, 0, 0,   1, 0, 3, 10, 0, 1, 1, 0, 1, 1, 7,   8'h00, 8'h02, 0, 1};
    tbl[2]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 1, 0, 3, 10,  8'h08, 8'h00, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    tbl[4]  = '{1, 1, 2, 17,  1, 1, 5, 2,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 1, 1};
    tbl[5]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0, 0, 1, 2, 17,  8'h00, 8'h24, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 1, 5, 2,   8'h00, 8'h20, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    tbl[8]  = '{1, 0, 0, 123, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    tbl[9]  = '{1, 1, 0, 7,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 123, 8'h01, 8'h00, 1, 0};
    tbl[10] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 7,   8'h00, 8'h01, 0, 0};
    tbl[11] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    tbl[12] = '{0, 0, 0, 0,   1, 1, 7, 77, 0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 1};
    tbl[13] = '{1, 1, 6, 66,  1, 0, 5, 55, 0, 1, 1, 0, 1, 7, 77,  8'h00, 8'h80, 1, 0};
    tbl[14] = '{0, 0, 0, 0,   1, 0, 2, 9,  1, 0, 0, 0, 1, 6, 66,  8'h20, 8'h40, 0, 0};
    tbl[15] = '{0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0,   8'h00, 8'h00, 0, 0};
    repeat (4) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk("rst.r0_ready", 64'(r0_ready), 64'd1);
    chk("rst.r1_ready", 64'(r1_ready), 64'd1);
    chk("rst.we", 64'({we_a, we_d}), 64'd0);
    chk("rst.waddr_wdata", 64'({waddr, wdata}), 64'd0);
    chk("rst.busy", 64'({busy_a, busy_d}), 64'd0);
`ifdef CPU_AD48_WB_ARB_STATS_EN
    chk("rst.conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      apply(tbl[k], $sformatf("row%0d", k));
`ifdef CPU_AD48_WB_ARB_STATS_EN
      if (k == 7) chk("tie.conflict_cnt", 64'(conflict_cnt), 64'd1);
`endif
    end
`ifdef CPU_AD48_WB_ARB_STATS_EN
    chk("flush.conflict_cnt", 64'(conflict_cnt), 64'd2);
`endif
    // reset while r1 holds a pending A5 write
    r0_valid = 1; r0_bank = 1; r0_idx = 3; r0_data = 33;
    exp_q.push_back('{b: 1'b1, i: 3'd3, d: 48'd33});
    @(negedge clk);
    chk("mrst.r0_ready", 64'(r0_ready), 64'd1);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 1; r1_bank = 0; r1_idx = 5; r1_data = 55;
    @(negedge clk);
    chk("mrst.r1_ready", 64'(r1_ready), 64'd1);
    @(posedge clk); #1;
    r1_valid = 0;
    chk("mrst.busy_pre", 64'(busy_a), 64'h20);
    resetn = 0;
    #1;
    chk("mrst.busy_a", 64'(busy_a), 64'd0);
    chk("mrst.we", 64'({we_a, we_d}), 64'd0);
    chk("mrst.ready", 64'({r0_ready, r1_ready}), 64'd3);
`ifdef CPU_AD48_WB_ARB_STATS_EN
    chk("mrst.conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    // continuous contention: grants must alternate 0,1,0,1,...
    begin
      int n0, n1;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 6; k++) begin
        logic e0, e1;
        e0 = (k == 0) || (k % 2 == 1);
        e1 = (k == 0) || (k % 2 == 0);
        r0_valid = 1; r0_bank = 1; r0_idx = 3'(1 + n0); r0_data = 48'(100 + n0);
        r1_valid = 1; r1_bank = 0; r1_idx = 3'(4 + n1); r1_data = 48'(200 + n1);
        if (e0) exp_q.push_back('{b: 1'b1, i: 3'(1 + n0), d: 48'(100 + n0)});
        if (e1) exp_q.push_back('{b: 1'b0, i: 3'(4 + n1), d: 48'(200 + n1)});
        @(negedge clk);
        chk($sformatf("cont%0d.r0_ready", k), 64'(r0_ready), 64'(e0));
        chk($sformatf("cont%0d.r1_ready", k), 64'(r1_ready), 64'(e1));
        @(posedge clk); #1;
        if (e0) n0++;
        if (e1) n1++;
      end
    end
    idle();
    idle();
    @(negedge clk);
    chk("cont.busy_clear", 64'({busy_a, busy_d}), 64'd0);
    chk("cont.we_idle", 64'({we_a, we_d}), 64'd0);
`ifdef CPU_AD48_WB_ARB_STATS_EN
    chk("cont.conflict_cnt", 64'(conflict_cnt), 64'd6);
`endif
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_ad48_wb_arb.md
# cpu_ad48_wb_arb

Write-back arbiter for the cpu_ad48 register files. It sits between two result producers and the single shared write port of RF_A/RF_D. Requester 0 is the ALU/ALUI execute stage and requester 1 is the load/long-latency unit. Each requester gets a one-entry holding slot. Full slots are drained onto the write port with round-robin arbitration. Writes to A0 are accepted and then discarded. A per-register busy scoreboard is exported for hazard checks.

## Interface
Parameters:
- DW, 48, data width of write-back value
- AW, 3, register index width (8 registers per bank)

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of both holding slots
- r0_valid / r1_valid  in  1  requester n presents a write
- r0_ready / r1_ready  out  1  requester n slot can accept this cycle
- r0_bank / r1_bank  in  1  target bank: 1 = D, 0 = A
- r0_idx / r1_idx  in  AW  target register index
- r0_data / r1_data  in  DW  write value
- we_a  out  1  write enable to RF_A
- we_d  out  1  write enable to RF_D
- waddr  out  AW  write index
- wdata  out  DW  write value
- busy_a  out  8  bit i set while any full slot targets Ai
- busy_d  out  8  bit i set while any full slot targets Di

## Operation
- Each requester has a slot {full, bank, idx, data}.
- A request is accepted at a rising edge when rn_valid && rn_ready. The slot then loads and full goes to 1.
- Slot-full flag per slot: `sn_full`.
- rn_ready = !flush && (!sn_full || sn_grant). This allows back-to-back accepts when the slot drains in the same cycle. The ready signal depends only on slot state and flush, never on rn_valid.
- Arbitration is combinational over full slots:
  - Only one slot full: that slot is granted.
  - Both slots full: grant goes to the slot that is not `last`.
  - `last` is a 1-bit register holding the id of the most recent grant. It is updated on every grant.
- Write-port outputs are driven combinationally from the granted slot:
  - we_d = grant && bank==1.
  - we_a = grant && bank==0 && idx!=0.
  - waddr and wdata come from the granted slot. They are 0 when there is no grant.
- A0 rule: a granted slot with bank=A, idx=0 is drained and counts as a grant (`last` updates), but we_a stays 0.
- A granted slot clears at the next edge, unless it is reloaded by a simultaneous accept. In that case it stays full with the new contents.
- busy_a and busy_d are combinational ORs of the decoded targets of the full slots. An A0 target sets busy_a[0].
- flush=1 clears both slots at the next edge. No accept happens during a flush cycle. The write for a slot granted in that cycle is still presented, so the RF commits it. `last` updates normally.

## Timing
- Reset values: both slots empty, last=1 (requester 0 wins the first tie), we_a=we_d=0, waddr=0, wdata=0, busy_a=busy_d=0, r0_ready=r1_ready=1, stats counter 0.
- Latency: a request accepted at edge E is presented on the write port in the cycle after E. The RF commits it at edge E+1 if the request wins. Each lost tie adds one cycle.
- Throughput: one write per cycle on the port. Each requester can sustain one write per cycle when uncontended. Under continuous contention each requester gets one write every 2 cycles.
- Stalled requesters see ready=0 until their slot is granted. They must hold valid, bank, idx and data stable while valid && !ready.
- Reset asserted mid-operation discards both slots immediately. No further write-port activity occurs.

## Configuration
- CPU_AD48_WB_ARB_STATS_EN defined:
  - Adds output port `conflict_cnt out 16`.
  - It increments at each edge where both slots are full and resetn=1, and saturates at 16'hFFFF.
  - It is cleared only by reset; flush does not affect it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- **Reset:** hold resetn=0 for 4 cycles, release -> both readys=1, we_a=we_d=0, busy_a=busy_d=0.
- **Single writes:** r0 writes D1=7, then r1 writes A3=10 in the next cycle -> we_d with waddr=1, wdata=7 one cycle after accept; then we_a with waddr=3, wdata=10; RF_D[1]=7 and RF_A[3]=10.
- **Tie:** both requesters valid in the same cycle (r0 D2=17, r1 D5=2) -> D2 written first, D5 the next cycle; r1_ready=0 for one cycle; under the stats macro conflict_cnt=1.
- **Continuous contention:** 6 cycles of continuous valid on both requesters with distinct targets -> grants alternate 0,1,0,1,0,1; no write lost; busy bits clear after the last write.
- **A0 discard:** r0 writes A0=123, followed immediately by r0 D0=7 -> no we_a pulse, A0 stays 0; D0=7 is written on the following cycle; busy_a[0] is set for one cycle.
- **Flush and reset mid-operation:** r1 stalled behind r0 with A5 pending, flush asserted -> A5 is never written, busy_a[5] clears, ready is low during the flush cycle. Repeat with resetn=0 instead -> no write, and the slot is empty immediately.
